// File: rtl/mem_arbiter.sv
// Two-master arbiter for one shared memory port: instruction fetch vs data access.
// Data normally wins; a bounded streak counter stops it from starving a pending fetch.
module mem_arbiter #(
   parameter int WIDTH      = 32,
   parameter int STREAK_MAX = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_ack,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic             busy
);

   localparam int SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
   localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_D = 3'd2,
      DONE_I  = 3'd3,
      DONE_D  = 3'd4
   } state_t;

   state_t           state_q;
   logic [SW-1:0]    streak_q;
   logic [SW-1:0]    streak_d;
   logic             sel_data;
   logic [WIDTH-1:0] if_rdata_q;
   logic [WIDTH-1:0] d_rdata_q;
   logic             if_ack_q;
   logic             d_ack_q;
   logic             mem_req_q;
   logic             mem_we_q;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic             busy_q;

   // Data wins unless a fetch is waiting and data has already had its full streak.
   always_comb begin
      sel_data = d_req && (!if_req || (streak_q < STREAK_TOP));
      streak_d = streak_q;
      if (if_req && (streak_q != STREAK_TOP)) begin
         streak_d = streak_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sel_data) begin
                  state_q     <= GRANT_D;
                  streak_q    <= streak_d;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= d_we;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
                  busy_q      <= 1'b1;
               end else if (if_req) begin
                  state_q    <= GRANT_I;
                  streak_q   <= '0;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= if_addr;
                  busy_q     <= 1'b1;
               end
            end
            GRANT_I: begin
               if (mem_ready) begin
                  state_q    <= DONE_I;
                  mem_req_q  <= 1'b0;
                  if_rdata_q <= mem_rdata;
                  if_ack_q   <= 1'b1;
               end
            end
            GRANT_D: begin
               // mem_we_q still holds the latched direction of this access.
               if (mem_ready) begin
                  state_q   <= DONE_D;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  if (!mem_we_q) begin
                     d_rdata_q <= mem_rdata;
                  end
                  d_ack_q <= 1'b1;
               end
            end
            DONE_I, DONE_D: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ack    = if_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_ack     = d_ack_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model with its own arbitration rule and reference memory.
module tb_mem_arbiter;
   localparam int W    = 32;
   localparam int SMAX = 4;

   logic         clk = 1'b0;
   logic         clr;
   logic         if_req;
   logic [W-1:0] if_addr;
   logic [W-1:0] if_rdata;
   logic         if_ack;
   logic         d_req;
   logic         d_we;
   logic [W-1:0] d_addr;
   logic [W-1:0] d_wdata;
   logic [W-1:0] d_rdata;
   logic         d_ack;
   logic         mem_req;
   logic         mem_we;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_wdata;
   logic [W-1:0] mem_rdata;
   logic         mem_ready;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] ref_mem [logic [W-1:0]];
   logic [W-1:0] dev_mem [logic [W-1:0]];

   mem_arbiter #(.WIDTH(W), .STREAK_MAX(SMAX)) dut (
      .clk(clk), .clr(clr),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [W-1:0] dev_rd(input logic [W-1:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
   endfunction

   // ctl vector below is {mem_req, mem_we, busy, if_ack, d_ack}
   task automatic test_reset();
      clr = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = '1; mem_ready = 1'b1;
      tick(); tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00000)
         $display("FAIL reset_ctl got=%b want=00000", {mem_req, mem_we, busy, if_ack, d_ack});
      else n_pass++;
      n_checks++;
      if ({mem_addr, mem_wdata} !== {2*W{1'b0}})
         $display("FAIL reset_mem got=%h/%h want=0/0", mem_addr, mem_wdata);
      else n_pass++;
      n_checks++;
      if ({if_rdata, d_rdata} !== {2*W{1'b0}})
         $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata, d_rdata);
      else n_pass++;
      clr = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; mem_ready = 1'b0;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00000)
         $display("FAIL reset_release got=%b want=00000", {mem_req, mem_we, busy, if_ack, d_ack});
      else n_pass++;
      $display("reset: done");
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         tick();
         n_checks++;
         if ({mem_req, busy, if_ack, d_ack} !== 4'b0000)
            $display("FAIL idle cyc=%0d got=%b want=0000", i, {mem_req, busy, if_ack, d_ack});
         else n_pass++;
      end
      mem_ready = 1'b0;
      $display("idle: 10 cycles");
   endtask

   task automatic test_zero_wait_fetch();
      if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b10100 || mem_addr !== 32'h10)
         $display("FAIL zw_grant got=%b/%h want=10100/00000010",
                  {mem_req, mem_we, busy, if_ack, d_ack}, mem_addr);
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00110 || if_rdata !== 32'hDEADBEEF)
         $display("FAIL zw_ack got=%b/%h want=00110/deadbeef",
                  {mem_req, mem_we, busy, if_ack, d_ack}, if_rdata);
      else n_pass++;
      if_req = 1'b0;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00000)
         $display("FAIL zw_after got=%b want=00000", {mem_req, mem_we, busy, if_ack, d_ack});
      else n_pass++;
      mem_ready = 1'b0;
      $display("txn fetch addr=00000010 zero-wait");
   endtask

   task automatic test_write_wait3();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
      mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b11100 ||
             {mem_addr, mem_wdata} !== {32'h40, 32'h1234})
            $display("FAIL wr_hold cyc=%0d got=%b/%h/%h want=11100/00000040/00001234", i,
                     {mem_req, mem_we, busy, if_ack, d_ack}, mem_addr, mem_wdata);
         else n_pass++;
         if (i == 3) mem_ready = 1'b1;
      end
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00101 || d_rdata !== 32'h0)
         $display("FAIL wr_ack got=%b/%h want=00101/00000000",
                  {mem_req, mem_we, busy, if_ack, d_ack}, d_rdata);
      else n_pass++;
      d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00000)
         $display("FAIL wr_after got=%b want=00000", {mem_req, mem_we, busy, if_ack, d_ack});
      else n_pass++;
      $display("txn write addr=00000040 data=00001234 waits=3");
   endtask

   task automatic test_collision();
      if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      mem_ready = 1'b1; mem_rdata = 32'h11111111;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b10100 || mem_addr !== 32'h30)
         $display("FAIL col_first got=%b/%h want=10100/00000030",
                  {mem_req, mem_we, busy, if_ack, d_ack}, mem_addr);
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00101 || d_rdata !== 32'h11111111)
         $display("FAIL col_dack got=%b/%h want=00101/11111111",
                  {mem_req, mem_we, busy, if_ack, d_ack}, d_rdata);
      else n_pass++;
      d_req = 1'b0; mem_rdata = 32'h22222222;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00000)
         $display("FAIL col_idle got=%b want=00000", {mem_req, mem_we, busy, if_ack, d_ack});
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b10100 || mem_addr !== 32'h20)
         $display("FAIL col_second got=%b/%h want=10100/00000020",
                  {mem_req, mem_we, busy, if_ack, d_ack}, mem_addr);
      else n_pass++;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00110 || if_rdata !== 32'h22222222)
         $display("FAIL col_iack got=%b/%h want=00110/22222222",
                  {mem_req, mem_we, busy, if_ack, d_ack}, if_rdata);
      else n_pass++;
      if_req = 1'b0; mem_ready = 1'b0;
      tick();
      $display("txn collision: data then fetch");
   endtask

   // Both masters hold requests; grants must follow DDDDI DDDDI.
   task automatic test_starvation();
      int   grants = 0;
      int   acks   = 0;
      int   cyc    = 0;
      logic prev   = 1'b0;
      logic want_fetch;
      logic got_fetch;
      if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      mem_ready = 1'b1; mem_rdata = 32'h33333333;
      while (acks < 10 && cyc < 200) begin
         tick();
         cyc++;
         if (mem_req && !prev) begin
            want_fetch = ((grants % (SMAX + 1)) == SMAX);
            got_fetch  = (mem_addr == 32'h200);
            n_checks++;
            if (got_fetch !== want_fetch)
               $display("FAIL starve_grant%0d fetch got=%b want=%b", grants, got_fetch, want_fetch);
            else n_pass++;
            grants++;
         end
         prev = mem_req;
         if (if_ack || d_ack) acks++;
      end
      if (acks < 10) begin
         n_checks++;
         $display("FAIL starve_timeout acks got=%0d want=10", acks);
      end
      if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      tick(); tick();
      $display("starvation: %0d grants observed", grants);
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_ready = 1'b0; mem_rdata = 32'h77777777;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b10100)
         $display("FAIL rm_grant got=%b want=10100", {mem_req, mem_we, busy, if_ack, d_ack});
      else n_pass++;
      tick();
      clr = 1'b1; mem_ready = 1'b1; if_req = 1'b1;
      tick();
      n_checks++;
      if ({mem_req, mem_we, busy, if_ack, d_ack} !== 5'b00000 ||
          {mem_addr, mem_wdata, if_rdata, d_rdata} !== {4*W{1'b0}})
         $display("FAIL rm_clear got=%b/%h/%h/%h/%h want=00000/0/0/0/0",
                  {mem_req, mem_we, busy, if_ack, d_ack}, mem_addr, mem_wdata, if_rdata, d_rdata);
      else n_pass++;
      clr = 1'b0; d_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
      tick();
      n_checks++;
      if ({mem_req, busy, if_ack, d_ack} !== 4'b0000)
         $display("FAIL rm_noack got=%b want=0000", {mem_req, busy, if_ack, d_ack});
      else n_pass++;
      $display("txn read addr=00000044 abandoned by reset");
   endtask

   task automatic test_random();
      bit           active = 0;
      bit           fin    = 0;
      bit           own_d  = 0;
      bit           drop_i;
      bit           drop_d;
      logic [W-1:0] t_addr  = '0;
      logic [W-1:0] t_wdata = '0;
      logic         t_we    = 1'b0;
      logic [W-1:0] e_if    = '0;
      logic [W-1:0] e_d     = '0;
      int           streak_m = 0;
      int           acks     = 0;
      int           cyc      = 0;
      clr = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      tick();
      clr = 1'b0;
      ref_mem.delete();
      dev_mem.delete();
      while (acks < 80 && cyc < 4000) begin
         tick();
         cyc++;
         n_checks++;
         if ({mem_req, busy, if_ack, d_ack} !== {active, active | fin, fin & ~own_d, fin & own_d})
            $display("FAIL rnd_ctl cyc=%0d got=%b want=%b", cyc, {mem_req, busy, if_ack, d_ack},
                     {active, active | fin, fin & ~own_d, fin & own_d});
         else n_pass++;
         n_checks++;
         if (active ? ({mem_addr, mem_we, (t_we ? mem_wdata : {W{1'b0}})} !==
                       {t_addr, t_we, (t_we ? t_wdata : {W{1'b0}})})
                    : (mem_we !== 1'b0))
            $display("FAIL rnd_mem cyc=%0d got=%h/%b/%h want=%h/%b/%h", cyc, mem_addr, mem_we,
                     mem_wdata, t_addr, t_we & active, t_wdata);
         else n_pass++;
         n_checks++;
         if ({if_rdata, d_rdata} !== {e_if, e_d})
            $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h/%h", cyc, if_rdata, d_rdata, e_if, e_d);
         else n_pass++;

         drop_i = 0; drop_d = 0;
         if (fin) begin
            acks++;
            $display("txn %0d: %s addr=%h we=%b", acks, own_d ? "data " : "fetch", t_addr, t_we);
            if (own_d) begin d_req = 1'b0; drop_d = 1; end
            else begin if_req = 1'b0; drop_i = 1; end
         end
         if (!if_req && !drop_i && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = W'($urandom_range(0, 15) << 2);
         end
         if (!d_req && !drop_d && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = W'($urandom_range(0, 15) << 2);
            d_wdata = $urandom;
         end

         mem_ready = ($urandom_range(0, 2) == 0);
         if (mem_req === 1'b1) begin
            mem_rdata = dev_rd(mem_addr);
            if (mem_we && mem_ready) dev_mem[mem_addr] = mem_wdata;
         end else begin
            mem_rdata = $urandom;
         end

         if (fin) begin
            fin = 0;
         end else if (active) begin
            if (mem_ready) begin
               active = 0;
               fin    = 1;
               if (!own_d)     e_if = ref_rd(t_addr);
               else if (!t_we) e_d  = ref_rd(t_addr);
               else            ref_mem[t_addr] = t_wdata;
            end
         end else if (if_req || d_req) begin
            own_d = d_req && (!if_req || streak_m < SMAX);
            if (own_d) begin
               if (if_req) streak_m = (streak_m < SMAX) ? streak_m + 1 : SMAX;
               t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
            end else begin
               streak_m = 0;
               t_addr = if_addr; t_we = 1'b0; t_wdata = '0;
            end
            active = 1;
         end
      end
      if (acks < 80) begin
         n_checks++;
         $display("FAIL rnd_timeout acks got=%0d want=80", acks);
      end
      if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      tick(); tick(); tick();
   endtask

   initial begin
      clr = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
      test_reset();
      test_idle();
      test_zero_wait_fetch();
      test_write_wait3();
      test_collision();
      test_starvation();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
